// File: rtl/note_pkg.sv
// Shared definitions for the PS/2 note-key controller: the note scan-code table,
// the prefix bytes and the byte-parser states.
package note_pkg;

   localparam int NUM_NOTES = 22;

   localparam logic [7:0] BREAK_PREFIX = 8'hF0;
   localparam logic [7:0] EXT_PREFIX   = 8'hE0;

   localparam logic [7:0] NOTE_CODES [NUM_NOTES] = '{
      8'h0D, 8'h16, 8'h15, 8'h1E, 8'h1D, 8'h24, 8'h25, 8'h2D, 8'h2E, 8'h2C, 8'h36,
      8'h35, 8'h3C, 8'h3E, 8'h43, 8'h46, 8'h44, 8'h4D, 8'h4E, 8'h54, 8'h55, 8'h5B
   };

   typedef enum logic [1:0] {
      StIdle,
      StBrk,
      StExt,
      StExtBrk
   } parse_state_e;

   function automatic logic is_note_code(input logic [7:0] code);
      logic hit;
      hit = 1'b0;
      for (int i = 0; i < NUM_NOTES; i++) begin
         if (NOTE_CODES[i] == code) hit = 1'b1;
      end
      return hit;
   endfunction

endpackage

// File: rtl/note_key_stack.sv
// Age-ordered store of held note keys: slot 0 is the oldest, slot count-1 the newest.
// Unused slots are kept at zero so removal can shift uniformly.
module note_key_stack
   import note_pkg::*;
#(
   parameter int unsigned Depth = 4,
   localparam int unsigned CntW = $clog2(Depth + 1),
   localparam int unsigned IdxW = $clog2(Depth)
) (
   input  logic            i_clk,
   input  logic            i_rst_n,
   input  logic            i_clear,
   input  logic            i_make,
   input  logic            i_break,
   input  logic [7:0]      i_code,
   output logic [7:0]      o_newest,
   output logic [CntW-1:0] o_count,
   output logic            o_evict
);

   logic [7:0]      r_keys [Depth];
   logic [CntW-1:0] r_count;
   logic            r_evict;

   logic [7:0]      w_keys_next [Depth];
   logic [CntW-1:0] w_count_next;
   logic            w_evict_next;
   logic            w_hit;
   logic [IdxW-1:0] w_hit_idx;
   logic            w_full;
   logic [IdxW-1:0] w_newest_idx;

   // Membership query restricted to the occupied slots.
   always_comb begin
      w_hit     = 1'b0;
      w_hit_idx = '0;
      for (int i = 0; i < Depth; i++) begin
         if (!w_hit && (CntW'(i) < r_count) && (r_keys[i] == i_code)) begin
            w_hit     = 1'b1;
            w_hit_idx = IdxW'(i);
         end
      end
   end

   assign w_full = (r_count == CntW'(Depth));

   always_comb begin
      w_keys_next  = r_keys;
      w_count_next = r_count;
      w_evict_next = 1'b0;
      if (i_clear) begin
         for (int i = 0; i < Depth; i++) w_keys_next[i] = '0;
         w_count_next = '0;
      end else if (i_make && !w_hit) begin
         if (w_full) begin
            for (int i = 0; i < Depth - 1; i++) w_keys_next[i] = r_keys[i+1];
            w_keys_next[Depth-1] = i_code;
            w_evict_next         = 1'b1;
         end else begin
            w_keys_next[r_count[IdxW-1:0]] = i_code;
            w_count_next                   = r_count + 1'b1;
         end
      end else if (i_break && w_hit) begin
         // Close the gap left by the released key, keeping age order.
         for (int i = 0; i < Depth - 1; i++) begin
            if (IdxW'(i) >= w_hit_idx) w_keys_next[i] = r_keys[i+1];
         end
         w_keys_next[Depth-1] = '0;
         w_count_next         = r_count - 1'b1;
      end
   end

   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         for (int i = 0; i < Depth; i++) r_keys[i] <= '0;
         r_count <= '0;
         r_evict <= 1'b0;
      end else begin
         r_keys  <= w_keys_next;
         r_count <= w_count_next;
         r_evict <= w_evict_next;
      end
   end

   assign w_newest_idx = IdxW'(r_count - 1'b1);

   always_comb begin
      o_newest = 8'h00;
      if (r_count != '0) o_newest = r_keys[w_newest_idx];
   end

   assign o_count = r_count;
   assign o_evict = r_evict;

endmodule

// File: rtl/key_note_controller.sv
// PS/2 scan-code parser driving a last-note-priority held-key stack; outputs are
// registered from the stack state, so each accepted byte shows one cycle later.
module key_note_controller
   import note_pkg::*;
#(
   parameter int unsigned DEPTH = 4,
   localparam int unsigned CntW = $clog2(DEPTH + 1)
) (
   input  logic            Clk,
   input  logic            Reset_n,
   input  logic [7:0]      ScanCode,
   input  logic            ScanValid,
   input  logic            Clear,
   output logic [7:0]      KeyboardData,
   output logic            Enable,
   output logic [CntW-1:0] HeldCount,
   output logic            Evicted
);

   parse_state_e    r_state;
   parse_state_e    w_state_next;
   logic            w_make;
   logic            w_break;
   logic            w_is_note;

   logic [7:0]      w_newest;
   logic [CntW-1:0] w_count;
   logic            w_evict;

   logic [7:0]      r_kbd;
   logic            r_enable;
   logic [CntW-1:0] r_held;
   logic            r_evicted;

   assign w_is_note = is_note_code(ScanCode);

   always_comb begin
      w_state_next = r_state;
      w_make       = 1'b0;
      w_break      = 1'b0;
      if (Clear) begin
         w_state_next = StIdle;
      end else if (ScanValid) begin
         case (r_state)
            StIdle: begin
               if (ScanCode == BREAK_PREFIX) begin
                  w_state_next = StBrk;
               end else if (ScanCode == EXT_PREFIX) begin
                  w_state_next = StExt;
               end else begin
                  w_make = w_is_note;
               end
            end
            StBrk: begin
               w_break      = w_is_note;
               w_state_next = StIdle;
            end
            // Extended keys never sound; swallow the byte.
            StExt: begin
               w_state_next = (ScanCode == BREAK_PREFIX) ? StExtBrk : StIdle;
            end
            default: w_state_next = StIdle;
         endcase
      end
   end

   note_key_stack #(
      .Depth (DEPTH)
   ) u_stack (
      .i_clk    (Clk),
      .i_rst_n  (Reset_n),
      .i_clear  (Clear),
      .i_make   (w_make),
      .i_break  (w_break),
      .i_code   (ScanCode),
      .o_newest (w_newest),
      .o_count  (w_count),
      .o_evict  (w_evict)
   );

   always_ff @(posedge Clk) begin
      if (!Reset_n) begin
         r_state   <= StIdle;
         r_kbd     <= 8'h00;
         r_enable  <= 1'b0;
         r_held    <= '0;
         r_evicted <= 1'b0;
      end else begin
         r_state   <= w_state_next;
         r_kbd     <= w_newest;
         r_enable  <= (w_count != '0);
         r_held    <= w_count;
         r_evicted <= w_evict;
      end
   end

   assign KeyboardData = r_kbd;
   assign Enable       = r_enable;
   assign HeldCount    = r_held;
   assign Evicted      = r_evicted;

endmodule

// File: tb/tb_key_note_controller.sv
// Directed and random stimulus for key_note_controller, checked against a queue-based
// model of held keys that trails the DUT outputs by one cycle.
module tb_key_note_controller;

   localparam int DEPTH = 4;
   localparam int HW    = $clog2(DEPTH + 1);

   logic          Clk = 1'b0;
   logic          Reset_n = 1'b0;
   logic [7:0]    ScanCode = 8'h00;
   logic          ScanValid = 1'b0;
   logic          Clear = 1'b0;
   logic [7:0]    KeyboardData;
   logic          Enable;
   logic [HW-1:0] HeldCount;
   logic          Evicted;

   key_note_controller #(
      .DEPTH (DEPTH)
   ) dut (
      .Clk          (Clk),
      .Reset_n      (Reset_n),
      .ScanCode     (ScanCode),
      .ScanValid    (ScanValid),
      .Clear        (Clear),
      .KeyboardData (KeyboardData),
      .Enable       (Enable),
      .HeldCount    (HeldCount),
      .Evicted      (Evicted)
   );

   always #5 Clk = ~Clk;

   int n_assert = 0;
   int n_fail   = 0;

   // Model: held keys oldest-first, pending prefix flags, evict flag of the last edge.
   logic [7:0] q[$];
   bit         brk_pend = 1'b0;
   bit         ext_pend = 1'b0;
   bit         ev_flag  = 1'b0;

   logic [7:0] exp_kbd;
   bit         exp_en;
   int         exp_cnt;
   bit         exp_ev;

   logic [7:0] picks [8] = '{8'h0D, 8'h16, 8'h15, 8'h1E, 8'h1D, 8'h24, 8'h5B, 8'h3C};

   function automatic bit is_note(input logic [7:0] c);
      return c inside {8'h0D, 8'h16, 8'h15, 8'h1E, 8'h1D, 8'h24, 8'h25, 8'h2D, 8'h2E, 8'h2C,
                       8'h36, 8'h35, 8'h3C, 8'h3E, 8'h43, 8'h46, 8'h44, 8'h4D, 8'h4E, 8'h54,
                       8'h55, 8'h5B};
   endfunction

   function automatic void model_update(input bit valid, input logic [7:0] code, input bit clr);
      int idx;
      ev_flag = 1'b0;
      if (clr) begin
         q.delete();
         brk_pend = 1'b0;
         ext_pend = 1'b0;
      end else if (valid) begin
         if (ext_pend) begin
            if (code == 8'hF0 && !brk_pend) brk_pend = 1'b1;
            else begin
               ext_pend = 1'b0;
               brk_pend = 1'b0;
            end
         end else if (!brk_pend && code == 8'hF0) begin
            brk_pend = 1'b1;
         end else if (!brk_pend && code == 8'hE0) begin
            ext_pend = 1'b1;
         end else begin
            if (is_note(code)) begin
               idx = -1;
               foreach (q[i]) if (q[i] == code) idx = i;
               if (brk_pend) begin
                  if (idx >= 0) q.delete(idx);
               end else if (idx < 0) begin
                  if (q.size() == DEPTH) begin
                     void'(q.pop_front());
                     ev_flag = 1'b1;
                  end
                  q.push_back(code);
               end
            end
            brk_pend = 1'b0;
         end
      end
   endfunction

   task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] want);
      n_assert++;
      assert (got === want)
      else begin
         n_fail++;
         $error("FAIL %s: got %h want %h", tag, got, want);
      end
   endtask

   task automatic step(input bit rst, input bit valid, input logic [7:0] code, input bit clr,
                       input string tag);
      @(negedge Clk);
      Reset_n   = !rst;
      ScanValid = valid;
      ScanCode  = code;
      Clear     = clr;
      @(posedge Clk);
      if (rst) begin
         exp_kbd  = 8'h00;
         exp_en   = 1'b0;
         exp_cnt  = 0;
         exp_ev   = 1'b0;
         q.delete();
         brk_pend = 1'b0;
         ext_pend = 1'b0;
         ev_flag  = 1'b0;
      end else begin
         exp_kbd = (q.size() != 0) ? q[$] : 8'h00;
         exp_en  = (q.size() != 0);
         exp_cnt = q.size();
         exp_ev  = ev_flag;
         model_update(valid, code, clr);
      end
      #1;
      chk({tag, " kbd"}, KeyboardData, exp_kbd);
      chk({tag, " en"}, {7'b0, Enable}, {7'b0, exp_en});
      chk({tag, " cnt"}, 8'(HeldCount), 8'(exp_cnt));
      chk({tag, " ev"}, {7'b0, Evicted}, {7'b0, exp_ev});
   endtask

   task automatic send(input logic [7:0] code, input string tag);
      step(1'b0, 1'b1, code, 1'b0, tag);
   endtask

   task automatic idle(input string tag);
      step(1'b0, 1'b0, 8'h00, 1'b0, tag);
   endtask

   initial begin
      bit         r_rst, r_clr, r_val;
      logic [7:0] r_code;
      int         sel;

      // Reset with strobes present: outputs stay empty.
      step(1'b1, 1'b0, 8'h00, 1'b0, "rst0");
      step(1'b1, 1'b1, 8'h15, 1'b0, "rst1");
      step(1'b1, 1'b1, 8'hF0, 1'b0, "rst2");
      idle("post_rst");

      // Single key press and release.
      send(8'h15, "mk15");
      send(8'hF0, "f0");
      chk("one_note_kbd", KeyboardData, 8'h15);
      chk("one_note_en", {7'b0, Enable}, 8'h01);
      send(8'h15, "brk15");
      idle("idle_a");
      chk("released_kbd", KeyboardData, 8'h00);
      chk("released_en", {7'b0, Enable}, 8'h00);

      // Two keys, release newer, typematic repeat of the older.
      send(8'h15, "mk15b");
      send(8'h1D, "mk1d");
      send(8'hF0, "f0b");
      chk("two_keys_kbd", KeyboardData, 8'h1D);
      chk("two_keys_cnt", 8'(HeldCount), 8'h02);
      send(8'h1D, "brk1d");
      send(8'h15, "rep15");
      idle("idle_b");
      chk("repeat_kbd", KeyboardData, 8'h15);
      chk("repeat_cnt", 8'(HeldCount), 8'h01);

      // Overflow evicts the oldest; breaking the evicted key is a no-op.
      step(1'b0, 1'b0, 8'h00, 1'b1, "clr_a");
      send(8'h0D, "e0d");
      send(8'h16, "e16");
      send(8'h15, "e15");
      send(8'h1E, "e1e");
      send(8'h1D, "e1d");
      idle("idle_c");
      chk("evict_pulse", {7'b0, Evicted}, 8'h01);
      chk("evict_cnt", 8'(HeldCount), 8'h04);
      chk("evict_kbd", KeyboardData, 8'h1D);
      send(8'hF0, "f0c");
      send(8'h0D, "brk0d");
      idle("idle_d");
      chk("stale_brk_kbd", KeyboardData, 8'h1D);
      chk("stale_brk_cnt", 8'(HeldCount), 8'h04);
      chk("stale_brk_ev", {7'b0, Evicted}, 8'h00);

      // Extended and non-note codes leave the stack alone.
      step(1'b0, 1'b0, 8'h00, 1'b1, "clr_b");
      send(8'hE0, "x1");
      send(8'h75, "x2");
      send(8'hE0, "x3");
      send(8'hF0, "x4");
      send(8'h75, "x5");
      send(8'h1C, "x6");
      send(8'hF0, "x7");
      send(8'h1C, "x8");
      send(8'h24, "x9");
      idle("idle_e");
      chk("ext_kbd", KeyboardData, 8'h24);
      chk("ext_cnt", 8'(HeldCount), 8'h01);

      // Reset discards a pending break prefix; Clear beats a coincident byte.
      send(8'hF0, "pre_rst");
      step(1'b1, 1'b0, 8'h00, 1'b0, "rst_mid");
      send(8'h15, "mk_after_rst");
      idle("idle_f");
      chk("after_rst_en", {7'b0, Enable}, 8'h01);
      step(1'b0, 1'b1, 8'h24, 1'b1, "clr_24");
      idle("idle_g");
      chk("clr_cnt", 8'(HeldCount), 8'h00);
      send(8'h24, "mk24");
      idle("idle_h");
      chk("clr_24_new", 8'(HeldCount), 8'h01);

      // Random traffic against the model.
      for (int n = 0; n < 500; n++) begin
         sel   = $urandom_range(0, 99);
         r_rst = (sel < 2);
         r_clr = (sel >= 2 && sel < 5);
         r_val = ($urandom_range(0, 3) != 0);
         sel   = $urandom_range(0, 9);
         if (sel < 5) r_code = picks[$urandom_range(0, 7)];
         else if (sel < 7) r_code = 8'hF0;
         else if (sel == 7) r_code = 8'hE0;
         else r_code = 8'($urandom_range(0, 255));
         step(r_rst, r_val, r_code, r_clr, "rnd");
      end
      idle("tail0");
      idle("tail1");

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule

// File: doc/key_note_controller.md
KEY_NOTE_CONTROLLER -- requirements
Module: key_note_controller

Interface
REQ-001 SHALL have parameter DEPTH, default 4, giving the number of simultaneously held note keys tracked (2..8).
REQ-002 SHALL have port Clk, input, 1 bit, the single clock; all state changes on its rising edge.
REQ-003 SHALL have port Reset_n, input, 1 bit, synchronous active-low reset.
REQ-004 SHALL have port ScanCode, input, 8 bits, PS/2 scan-code byte.
REQ-005 SHALL have port ScanValid, input, 1 bit, one-cycle strobe qualifying ScanCode.
REQ-006 SHALL have port Clear, input, 1 bit, synchronous all-notes-off.
REQ-007 SHALL have port KeyboardData, output, 8 bits, scan code of the sounding note, driven to the frequency lookup; 8'h00 when none.
REQ-008 SHALL have port Enable, output, 1 bit, high while at least one note key is held.
REQ-009 SHALL have port HeldCount, output, clog2(DEPTH+1) bits, number of held note keys.
REQ-010 SHALL have port Evicted, output, 1 bit, one-cycle pulse when the oldest held key is dropped to make room.

Function
REQ-011 SHALL parse bytes with FSM states IDLE, BRK (after 8'hF0), EXT (after 8'hE0), EXT_BRK (after E0 F0).
REQ-012 SHALL transition IDLE->BRK on F0, IDLE->EXT on E0, EXT->EXT_BRK on F0; any other byte returns to IDLE after being processed.
REQ-013 SHALL discard extended codes: a byte accepted in EXT or EXT_BRK (other than F0 in EXT) causes no stack change and returns to IDLE.
REQ-014 SHALL treat a byte in IDLE as a make and a byte in BRK as a break; only the 22 note codes (0D,16,15,1E,1D,24,25,2D,2E,2C,36,35,3C,3E,43,46,44,4D,4E,54,55,5B) affect the stack; others are ignored.
REQ-015 SHALL on make of an absent note code with stack not full push it as newest.
REQ-016 SHALL on make of an absent note code with stack full drop the oldest entry, shift, push the new code as newest, and pulse Evicted for one cycle.
REQ-017 SHALL ignore make of a code already held (typematic repeat): no reorder, no count change.
REQ-018 SHALL on break of a held code remove it and compact remaining entries preserving age order; break of a non-held code is ignored.
REQ-019 SHALL drive KeyboardData = newest entry and Enable = (HeldCount != 0), registered; a byte accepted at edge N is reflected on outputs after edge N+1 (one-cycle latency).
REQ-020 SHALL give Clear priority over ScanValid in the same cycle: stack emptied, parser to IDLE, byte dropped.
REQ-021 SHALL ignore ScanCode when ScanValid is low; no state change.

Reset
REQ-022 SHALL on Reset_n low at a rising edge set parser to IDLE, empty the stack, KeyboardData=8'h00, Enable=0, HeldCount=0, Evicted=0.
REQ-023 SHALL discard a pending F0/E0 prefix on reset; the first byte after reset is parsed from IDLE.
REQ-024 SHALL give reset priority over Clear and ScanValid.

Structure
REQ-025 SHALL place in shared package note_pkg: the 22-entry note scan-code table, BREAK_PREFIX=8'hF0, EXT_PREFIX=8'hE0, the parser state enum, and an is_note_code function.
REQ-026 SHALL implement the ordered held-key store (push, evict-oldest, remove-and-compact, membership query) as sub-module note_key_stack; the parser FSM stays in key_note_controller.

Verification
REQ-027 SHALL cover: reset with ScanValid pulsing -> KeyboardData=00, Enable=0, HeldCount=0 throughout.
REQ-028 SHALL cover: bytes 15 then F0,15 -> KeyboardData=15/Enable=1 one cycle after the 15, then 00/0 one cycle after the final 15.
REQ-029 SHALL cover: 15, 1D, F0,1D -> KeyboardData 15, 1D, back to 15; HeldCount 1,2,1; repeat make 15 leaves HeldCount=1.
REQ-030 SHALL cover (DEPTH=4): makes 0D,16,15,1E,1D -> Evicted pulse on the 1D, HeldCount=4, KeyboardData=1D; then F0,0D -> no change.
REQ-031 SHALL cover: E0,75; E0,F0,75; 1C; F0,1C -> no stack change, parser back in IDLE, next 24 sounds KeyboardData=24.
REQ-032 SHALL cover: F0 then Reset_n low one cycle then 15 -> 15 treated as make (Enable=1); Clear coincident with ScanValid(24) -> HeldCount=0, 24 not held.
